// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode codes, exponent limits, flag bit
// positions and the packed single-precision word layout.
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int EXP_MAX    = 255;
  localparam int EXP_MAXFIN = 254;

  localparam int FLG_OV = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

endpackage

// File: rtl/fpu_ovf_result.sv
// Selects the overflow result (infinity or largest finite) from rounding
// mode and sign; modes outside the defined set behave as round-to-nearest.
module fpu_ovf_result
  import fpu_pkg::*;
(
  input  logic [2:0] rmode,
  input  logic       sign,
  output fp32_t      result
);

  logic use_inf;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    use_inf = 1'b1;
    case (rmode)
      RM_RTZ:  use_inf = 1'b0;
      RM_RDN:  use_inf = sign;
      RM_RUP:  use_inf = ~sign;
      default: use_inf = 1'b1;
    endcase
  end

  always_comb begin
    result.sign = sign;
    if (use_inf) begin
      result.exp  = 8'(EXP_MAX);
      result.frac = '0;
    end else begin
      result.exp  = 8'(EXP_MAXFIN);
      result.frac = '1;
    end
  end

endmodule

// File: rtl/fpu_round_pack.sv
// Post-rounding exponent adjust and IEEE-754 single pack, two-stage
// valid/ready pipeline. Define FPU_STICKY_FLAGS_EN for accumulated flags.
module fpu_round_pack
  import fpu_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [23:0]             in_mant,
  input  logic                    in_ovf_rnd,
  input  logic                    in_inexact,
  input  logic [2:0]              in_rmode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic [2:0]              out_flags
`ifdef FPU_STICKY_FLAGS_EN
  ,
  input  logic                    flags_clr,
  output logic [2:0]              sticky_flags
`endif
);

  // One extra bit so in_exp+1 cannot wrap at the top of the range.
  typedef logic signed [EXP_W:0] exp_t;
  localparam exp_t E_OVF = exp_t'(EXP_MAX);

  exp_t        e_adj;
  logic [22:0] frac_adj;
  logic        ov_adj, neg_adj, uf_adj;

  logic        s1_valid, s1_sign, s1_ov, s1_neg, s1_uf, s1_nx;
  logic [7:0]  s1_exp;
  logic [22:0] s1_frac;
  logic [2:0]  s1_rmode;
  logic        s2_valid;
  logic        s2_adv;

  fp32_t       ovf_word;
  fp32_t       pack_word;
  logic [2:0]  pack_flags;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;

  always_comb begin
    e_adj    = exp_t'(in_exp);
    frac_adj = in_mant[22:0];
    if (in_ovf_rnd) begin
      e_adj    = exp_t'(in_exp) + exp_t'(1);
      frac_adj = in_mant[23:1];
    end else if (in_exp == '0 && in_mant[23]) begin
      e_adj = exp_t'(1);
    end
  end

  assign ov_adj  = (e_adj >= E_OVF);
  assign neg_adj = e_adj[EXP_W];
  assign uf_adj  = neg_adj || (e_adj == '0 && in_inexact);

  // NOTE: the datapath registers are reset along with the valids so that
  // out_result/out_flags read as zero after reset, not just stale-but-invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_ov    <= 1'b0;
      s1_neg   <= 1'b0;
      s1_uf    <= 1'b0;
      s1_nx    <= 1'b0;
      s1_rmode <= RM_RNE;
    end else if (in_ready) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= in_sign;
        s1_exp   <= e_adj[7:0];
        s1_frac  <= frac_adj;
        s1_ov    <= ov_adj;
        s1_neg   <= neg_adj;
        s1_uf    <= uf_adj;
        s1_nx    <= in_inexact;
        s1_rmode <= in_rmode;
      end
    end
  end

  fpu_ovf_result u_ovf (
    .rmode  (s1_rmode),
    .sign   (s1_sign),
    .result (ovf_word)
  );

  always_comb begin
    pack_word  = '{sign: s1_sign, exp: s1_exp, frac: s1_frac};
    pack_flags = '0;
    if (s1_ov) begin
      pack_word          = ovf_word;
      pack_flags[FLG_OV] = 1'b1;
      pack_flags[FLG_NX] = 1'b1;
    end else if (s1_neg) begin
      pack_word          = '{sign: s1_sign, exp: '0, frac: '0};
      pack_flags[FLG_UF] = 1'b1;
      pack_flags[FLG_NX] = 1'b1;
    end else begin
      pack_flags[FLG_UF] = s1_uf;
      pack_flags[FLG_NX] = s1_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= pack_word;
        out_flags  <= pack_flags;
      end
    end
  end

`ifdef FPU_STICKY_FLAGS_EN
  logic out_xfer;
  assign out_xfer = s2_valid && out_ready;

  // A clear coinciding with a transfer keeps that transfer's flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else if (flags_clr) begin
      sticky_flags <= out_xfer ? out_flags : 3'b000;
    end else if (out_xfer) begin
      sticky_flags <= sticky_flags | out_flags;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_round_pack.sv
// Self-checking bench for fpu_round_pack: vector table through a scoreboard,
// plus backpressure, mid-flight reset and (when enabled) sticky-flag sequences.
module tb_fpu_round_pack;

  localparam int EXP_W = 10;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic signed [EXP_W-1:0] in_exp;
  logic [23:0]             in_mant;
  logic                    in_ovf_rnd;
  logic                    in_inexact;
  logic [2:0]              in_rmode;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_result;
  logic [2:0]              out_flags;
`ifdef FPU_STICKY_FLAGS_EN
  logic                    flags_clr;
  logic [2:0]              sticky_flags;
`endif

  always #5 clk = ~clk;

  fpu_round_pack #(.EXP_W(EXP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_ovf_rnd (in_ovf_rnd),
    .in_inexact (in_inexact),
    .in_rmode   (in_rmode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
`ifdef FPU_STICKY_FLAGS_EN
    ,
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic        ovf;
    logic        nx;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_res_t;

  localparam int NVEC = 17;
  vec_t     vecs [NVEC];
  exp_res_t sb [$];
  exp_res_t cur_exp;

  int n_vec   = 0;
  int n_err   = 0;
  int acc_cnt = 0;
  int out_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: push on input acceptance, pop and compare on output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %0h with nothing outstanding", out_result);
        end else begin
          exp_res_t e;
          e = sb.pop_front();
          check("result", out_result, e.res);
          check("flags", {29'd0, out_flags}, {29'd0, e.flg});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the vector is accepted.
  task automatic send(input vec_t v);
    bit ok;
    ok         = 1'b0;
    in_valid   = 1'b1;
    in_sign    = v.sign;
    in_exp     = v.exp;
    in_mant    = v.mant;
    in_ovf_rnd = v.ovf;
    in_inexact = v.nx;
    in_rmode   = v.rm;
    cur_exp    = '{res: v.res, flg: v.flg};
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready never asserted");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int acc0, out0;
    //             sign exp      mant      ovf  nx   rm      result        flags
    vecs[0]  = '{1'b0, 10'd127, 24'h0,      1'b1, 1'b0, 3'b000, 32'h40000000, 3'b000};
    vecs[1]  = '{1'b1, 10'd254, 24'h0,      1'b1, 1'b0, 3'b000, 32'hFF800000, 3'b101};
    vecs[2]  = '{1'b1, 10'd254, 24'h0,      1'b1, 1'b0, 3'b001, 32'hFF7FFFFF, 3'b101};
    vecs[3]  = '{1'b1, 10'd254, 24'h0,      1'b1, 1'b0, 3'b011, 32'hFF7FFFFF, 3'b101};
    vecs[4]  = '{1'b1, 10'd254, 24'h0,      1'b1, 1'b0, 3'b010, 32'hFF800000, 3'b101};
    vecs[5]  = '{1'b0, 10'd254, 24'h0,      1'b1, 1'b0, 3'b010, 32'h7F7FFFFF, 3'b101};
    vecs[6]  = '{1'b0, 10'd254, 24'h0,      1'b1, 1'b0, 3'b011, 32'h7F800000, 3'b101};
    vecs[7]  = '{1'b0, 10'd254, 24'h0,      1'b1, 1'b0, 3'b100, 32'h7F800000, 3'b101};
    vecs[8]  = '{1'b0, 10'd254, 24'h0,      1'b1, 1'b0, 3'b101, 32'h7F800000, 3'b101};
    vecs[9]  = '{1'b0, 10'd0,   24'h800000, 1'b0, 1'b0, 3'b000, 32'h00800000, 3'b000};
    vecs[10] = '{1'b0, 10'd0,   24'h400001, 1'b0, 1'b1, 3'b000, 32'h00400001, 3'b011};
    vecs[11] = '{1'b1, 10'h3FD, 24'h800000, 1'b0, 1'b0, 3'b000, 32'h80000000, 3'b011};
    vecs[12] = '{1'b1, 10'd130, 24'hC00000, 1'b0, 1'b1, 3'b001, 32'hC1400000, 3'b001};
    vecs[13] = '{1'b0, 10'd255, 24'h800000, 1'b0, 1'b0, 3'b000, 32'h7F800000, 3'b101};
    vecs[14] = '{1'b0, 10'h3FF, 24'h0,      1'b1, 1'b1, 3'b000, 32'h00000000, 3'b011};
    vecs[15] = '{1'b0, 10'd0,   24'h800000, 1'b0, 1'b1, 3'b000, 32'h00800000, 3'b001};
    vecs[16] = '{1'b0, 10'd253, 24'h0,      1'b1, 1'b0, 3'b000, 32'h7F000000, 3'b000};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sign    = 1'b0;
    in_exp     = '0;
    in_mant    = '0;
    in_ovf_rnd = 1'b0;
    in_inexact = 1'b0;
    in_rmode   = 3'b000;
    out_ready  = 1'b1;
    cur_exp    = '0;
`ifdef FPU_STICKY_FLAGS_EN
    flags_clr  = 1'b0;
`endif
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", {29'd0, out_flags}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
`ifdef FPU_STICKY_FLAGS_EN
    check("rst_sticky", {29'd0, sticky_flags}, 0);
`endif

    // Full-throughput pass over the table.
    for (int i = 0; i < NVEC; i++) send(vecs[i]);
    drain();

    // Backpressure: 4 back-to-back inputs, output stalled for 5 cycles.
    acc0      = acc_cnt;
    out0      = out_cnt;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(vecs[9 + i]);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        check("bp_in_ready_low", {31'd0, in_ready}, 0);
        check("bp_accepts", acc_cnt - acc0, 2);
        check("bp_out_held", {31'd0, out_valid}, 1);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_outputs", out_cnt - out0, 4);

    // Async reset with two entries held: nothing may emerge afterwards.
    out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[1]);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 0);
    check("arst_out_result", out_result, 0);
    sb.delete();
    out0 = out_cnt;
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("arst_no_output", out_cnt - out0, 0);
    check("arst_in_ready", {31'd0, in_ready}, 1);

`ifdef FPU_STICKY_FLAGS_EN
    flags_clr = 1'b1;
    @(posedge clk);
    #1;
    flags_clr = 1'b0;
    check("sticky_cleared", {29'd0, sticky_flags}, 0);
    send(vecs[1]);
    drain();
    check("sticky_after_ovf", {29'd0, sticky_flags}, 3'b101);
    send(vecs[0]);
    drain();
    check("sticky_after_clean", {29'd0, sticky_flags}, 3'b101);
    flags_clr = 1'b1;
    @(posedge clk);
    #1;
    flags_clr = 1'b0;
    check("sticky_after_clr", {29'd0, sticky_flags}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
